// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the core-side memory bridge: region codes, FSM states,
// the video window tag and the byte-lane helper.
package mem_bridge_pkg;

   localparam logic [1:0] REG_SRAM = 2'd0;
   localparam logic [1:0] REG_VID  = 2'd1;
   localparam logic [1:0] REG_ROM  = 2'd2;

   // cpu_address[19:15] of the B8000-BFFFF text-mode window
   localparam logic [4:0] VID_WINDOW = 5'b10111;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic logic [1:0] lane_be(input logic byte_sel);
      return byte_sel ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mem_decode.sv
// Combinational address decode: picks SRAM, video or write-protected ROM and
// produces the target strobes. force_sram lets the boot copier bypass protection.
module mem_decode
   import mem_bridge_pkg::*;
#(
   parameter logic [19:0] ROM_BASE = 20'hF0000
) (
   input  logic [19:0] address,
   input  logic        wren,
   input  logic        force_sram,
   output logic [1:0]  region,
   output logic [18:0] sram_addr,
   output logic [1:0]  sram_be,
   output logic        sram_we,
   output logic [14:0] vid_addr,
   output logic        vid_we
);

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      region    = REG_SRAM;
      sram_addr = address[19:1];
      sram_be   = lane_be(address[0]);
      vid_addr  = address[14:0];
      sram_we   = 1'b0;
      vid_we    = 1'b0;

      if (force_sram)
         region = REG_SRAM;
      else if (address[19:15] == VID_WINDOW)
         region = REG_VID;
      else if (address >= ROM_BASE)
         region = REG_ROM;

      // ROM-region writes fall through with both strobes low
      sram_we = wren && (region == REG_SRAM);
      vid_we  = wren && (region == REG_VID);
   end

endmodule

// File: rtl/mem_bridge.sv
// Memory-side responder for the 8-bit core: copies the boot image into SRAM
// while holding the core, then routes core accesses to SRAM or video RAM.
module mem_bridge
   import mem_bridge_pkg::*;
#(
   parameter int          BOOT_AW   = 12,
   parameter int          BOOT_LEN  = 4096,
   parameter logic [19:0] BOOT_BASE = 20'hFF000,
   parameter logic [19:0] ROM_BASE  = 20'hF0000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [19:0]        cpu_address,
   input  logic [7:0]         cpu_out,
   input  logic               cpu_wren,
   output logic [7:0]         cpu_data,
   output logic               hold,
   output logic [18:0]        sram_addr,
   output logic [15:0]        sram_wdata,
   output logic [1:0]         sram_be,
   output logic               sram_we,
   input  logic [15:0]        sram_rdata,
   output logic [14:0]        vid_addr,
   output logic [7:0]         vid_wdata,
   output logic               vid_we,
   input  logic [7:0]         vid_rdata,
   output logic [BOOT_AW-1:0] boot_addr,
   input  logic [7:0]         boot_data
);

   // one extra bit so cnt can reach BOOT_LEN == 2**BOOT_AW
   localparam int               CNT_W = BOOT_AW + 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(BOOT_LEN);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             booting;
   logic [19:0]      boot_byte;
   logic [19:0]      dec_addr;
   logic             dec_wren;
   logic [1:0]       dec_region;
   logic [1:0]       rd_region;
   logic             rd_lane;

   assign booting = (state == ST_BOOT);
   assign hold    = booting;

   // boot ROM data lags its address by a cycle, so byte cnt-1 lands now
   assign boot_byte = BOOT_BASE + 20'(cnt) - 20'd1;
   assign boot_addr = (booting && cnt < LAST) ? cnt[BOOT_AW-1:0] : '0;

   assign dec_addr = booting ? boot_byte : cpu_address;
   assign dec_wren = booting ? (cnt != '0) : cpu_wren;

   mem_decode #(.ROM_BASE(ROM_BASE)) u_decode (
      .address    (dec_addr),
      .wren       (dec_wren),
      .force_sram (booting),
      .region     (dec_region),
      .sram_addr  (sram_addr),
      .sram_be    (sram_be),
      .sram_we    (sram_we),
      .vid_addr   (vid_addr),
      .vid_we     (vid_we)
   );

   assign sram_wdata = booting ? {boot_data, boot_data} : {cpu_out, cpu_out};
   assign vid_wdata  = cpu_out;

   always_ff @(posedge clock or posedge reset) begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      if (reset) begin
         state <= ST_BOOT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (state == ST_BOOT) begin
         cnt_nxt = cnt + CNT_W'(1);
         if (cnt == LAST)
            state_nxt = ST_RUN;
      end
   end

   // select for the read data that returns one cycle after the address
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_region <= REG_SRAM;
         rd_lane   <= 1'b0;
      end else begin
         rd_region <= dec_region;
         rd_lane   <= cpu_address[0];
      end
   end

   always_comb begin
      cpu_data = 8'h00;
      if (!booting) begin
         if (rd_region == REG_VID)
            cpu_data = vid_rdata;
         else
            cpu_data = rd_lane ? sram_rdata[15:8] : sram_rdata[7:0];
      end
   end

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: byte-level reference memory predicts every
// read; a separate monitor compares cpu_data when each read returns.
module tb_mem_bridge;

   localparam int          BOOT_AW   = 12;
   localparam int          BOOT_LEN  = 4;
   localparam logic [19:0] BOOT_BASE = 20'hFF000;
   localparam logic [19:0] ROM_BASE  = 20'hF0000;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic [19:0]        cpu_address = '0;
   logic [7:0]         cpu_out = '0;
   logic               cpu_wren = 1'b0;
   logic [7:0]         cpu_data;
   logic               hold;
   logic [18:0]        sram_addr;
   logic [15:0]        sram_wdata;
   logic [1:0]         sram_be;
   logic               sram_we;
   logic [15:0]        sram_rdata;
   logic [14:0]        vid_addr;
   logic [7:0]         vid_wdata;
   logic               vid_we;
   logic [7:0]         vid_rdata;
   logic [BOOT_AW-1:0] boot_addr;
   logic [7:0]         boot_data;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clock = ~clock;

   mem_bridge #(
      .BOOT_AW(BOOT_AW), .BOOT_LEN(BOOT_LEN), .BOOT_BASE(BOOT_BASE), .ROM_BASE(ROM_BASE)
   ) dut (
      .clock(clock), .reset(reset),
      .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_wren(cpu_wren),
      .cpu_data(cpu_data), .hold(hold),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_be(sram_be),
      .sram_we(sram_we), .sram_rdata(sram_rdata),
      .vid_addr(vid_addr), .vid_wdata(vid_wdata), .vid_we(vid_we), .vid_rdata(vid_rdata),
      .boot_addr(boot_addr), .boot_data(boot_data)
   );

   // ---------------- device models (SRAM, video RAM, boot ROM) ----------------
   logic [15:0] sram_mem     [0:524287];
   bit          sram_written [0:524287];
   logic [7:0]  vid_mem      [0:32767];
   bit          vid_written  [0:32767];

   function automatic logic [7:0] init_byte(input logic [19:0] a);
      return a[7:0] ^ a[15:8] ^ {a[19:16], 4'h5} ^ 8'h3C;
   endfunction

   function automatic logic [7:0] init_vid(input logic [14:0] a);
      return a[7:0] ^ {1'b0, a[14:8]} ^ 8'hA7;
   endfunction

   function automatic logic [15:0] sram_word(input logic [18:0] w);
      return sram_written[w] ? sram_mem[w] : {init_byte({w, 1'b1}), init_byte({w, 1'b0})};
   endfunction

   function automatic logic [7:0] vid_byte(input logic [14:0] a);
      return vid_written[a] ? vid_mem[a] : init_vid(a);
   endfunction

   function automatic logic [7:0] rom_byte(input int a);
      case (a)
         0:       return 8'h11;
         1:       return 8'h22;
         2:       return 8'h33;
         3:       return 8'h44;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                         input logic [1:0] be);
      return {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
   endfunction

   always @(posedge clock) begin
      if (sram_we) begin
         sram_mem[sram_addr]     <= merge(sram_word(sram_addr), sram_wdata, sram_be);
         sram_written[sram_addr] <= 1'b1;
      end
      sram_rdata <= sram_we ? merge(sram_word(sram_addr), sram_wdata, sram_be)
                            : sram_word(sram_addr);
      if (vid_we) begin
         vid_mem[vid_addr]     <= vid_wdata;
         vid_written[vid_addr] <= 1'b1;
      end
      vid_rdata <= vid_we ? vid_wdata : vid_byte(vid_addr);
      boot_data <= rom_byte(int'(boot_addr));
      cyc       <= cyc + 1;
   end

   // ---------------- reference model: flat byte address space ----------------
   logic [7:0] ref_sram [logic [19:0]];
   logic [7:0] ref_vid  [logic [14:0]];

   function automatic bit in_vid(input logic [19:0] a);
      return a >= 20'hB8000 && a <= 20'hBFFFF;
   endfunction

   function automatic logic [7:0] ref_read(input logic [19:0] a);
      if (in_vid(a))
         return ref_vid.exists(a[14:0]) ? ref_vid[a[14:0]] : init_vid(a[14:0]);
      return ref_sram.exists(a) ? ref_sram[a] : init_byte(a);
   endfunction

   typedef struct {
      int          due;
      logic [7:0]  exp;
      logic [19:0] addr;
   } exp_t;

   exp_t sb_q[$];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, actual, expected);
      end
   endtask

   // monitor: pops each predicted read in the cycle its data is due
   initial forever begin
      @(negedge clock);
      while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
         check($sformatf("late read %05h", sb_q[0].addr), 32'(cyc), 32'(sb_q[0].due));
         void'(sb_q.pop_front());
      end
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
         check($sformatf("read %05h", sb_q[0].addr), 32'(cpu_data), 32'(sb_q[0].exp));
         void'(sb_q.pop_front());
      end
   end

   // one core bus cycle; strobes are checked mid-cycle, reads go to the scoreboard
   task automatic access(input logic [19:0] a, input logic wr, input logic [7:0] d);
      bit is_vid, is_rom;
      @(negedge clock);
      #1;
      cpu_address = a;
      cpu_wren    = wr;
      cpu_out     = d;
      #1;
      is_vid = in_vid(a);
      is_rom = !is_vid && a >= ROM_BASE;
      check($sformatf("sram_we %05h", a), 32'(sram_we), 32'(wr && !is_vid && !is_rom));
      check($sformatf("vid_we %05h", a), 32'(vid_we), 32'(wr && is_vid));
      check($sformatf("sram_addr %05h", a), 32'(sram_addr), 32'(a >> 1));
      check($sformatf("vid_addr %05h", a), 32'(vid_addr), 32'(a % 20'h08000));
      if (!is_vid)
         check($sformatf("sram_be %05h", a), 32'(sram_be), (a % 2 == 1) ? 32'd2 : 32'd1);
      if (wr && !is_vid && !is_rom)
         check($sformatf("sram_wdata %05h", a), 32'(sram_wdata), {16'h0, d, d});
      if (wr && is_vid)
         check($sformatf("vid_wdata %05h", a), 32'(vid_wdata), 32'(d));
      if (wr) begin
         if (is_vid)
            ref_vid[a[14:0]] = d;
         else if (!is_rom)
            ref_sram[a] = d;
      end else begin
         sb_q.push_back('{cyc + 1, ref_read(a), a});
      end
   endtask

   // call right after reset is released on a falling edge
   task automatic run_boot();
      logic [19:0] ba;
      for (int i = 0; i <= BOOT_LEN; i++) begin
         #2;
         ba = BOOT_BASE + 20'(i) - 20'd1;
         check("hold during boot", 32'(hold), 32'd1);
         check("cpu_data during boot", 32'(cpu_data), 32'd0);
         check("boot sram_we", 32'(sram_we), 32'(i >= 1));
         check("boot vid_we", 32'(vid_we), 32'd0);
         if (i < BOOT_LEN)
            check("boot_addr", 32'(boot_addr), 32'(i));
         if (i >= 1) begin
            check("boot sram_addr", 32'(sram_addr), 32'(ba >> 1));
            check("boot sram_be", 32'(sram_be), (ba % 2 == 1) ? 32'd2 : 32'd1);
            check("boot sram_wdata", 32'(sram_wdata), {16'h0, rom_byte(i - 1), rom_byte(i - 1)});
         end
         @(negedge clock);
      end
      #2;
      check("hold after boot", 32'(hold), 32'd0);
      for (int i = 0; i < BOOT_LEN; i++)
         ref_sram[BOOT_BASE + 20'(i)] = rom_byte(i);
   endtask

   initial begin
      logic [19:0] a;
      repeat (3) @(negedge clock);
      #2;
      check("hold in reset", 32'(hold), 32'd1);
      check("boot_addr in reset", 32'(boot_addr), 32'd0);
      check("sram_we in reset", 32'(sram_we), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      run_boot();
      check("boot word 7F800", 32'(sram_word(19'h7F800)), 32'h2211);
      check("boot word 7F801", 32'(sram_word(19'h7F801)), 32'h4433);

      // directed RUN traffic
      access(20'h00001, 1'b1, 8'hA5);
      access(20'h00001, 1'b0, 8'h00);
      access(20'h00000, 1'b0, 8'h00);
      access(20'hB8000, 1'b1, 8'h41);
      access(20'hB8000, 1'b0, 8'h00);
      access(20'hF0000, 1'b1, 8'h00);
      access(20'hF0000, 1'b0, 8'h00);
      access(20'hFF000, 1'b0, 8'h00);
      access(20'hFF003, 1'b0, 8'h00);
      access(20'hFFFFF, 1'b0, 8'h00);
      access(20'hBFFFF, 1'b1, 8'h9E);
      access(20'hBFFFF, 1'b0, 8'h00);
      access(20'hC0000, 1'b1, 8'h7B);
      access(20'hC0000, 1'b0, 8'h00);
      access(20'hEFFFF, 1'b1, 8'h3D);
      access(20'hEFFFF, 1'b0, 8'h00);

      // alternating SRAM high lane / video reads
      access(20'hB7FFF, 1'b1, 8'h5C);
      for (int i = 0; i < 8; i++) begin
         access(20'hB7FFF, 1'b0, 8'h00);
         access(20'hB8000, 1'b0, 8'h00);
      end

      // randomized traffic over small windows to force collisions
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 4))
            0:       a = 20'($urandom_range(0, 63));
            1:       a = 20'hB8000 + 20'($urandom_range(0, 63));
            2:       a = 20'hB7FC0 + 20'($urandom_range(0, 63));
            3:       a = 20'hF0000 + 20'($urandom_range(0, 63));
            default: a = 20'hFFFC0 + 20'($urandom_range(0, 63));
         endcase
         access(a, 1'($urandom_range(0, 9) < 4), 8'($urandom));
      end

      // drain, then reset mid-RUN and again at boot cycle 2
      @(negedge clock);
      cpu_wren = 1'b0;
      repeat (3) @(negedge clock);
      check("scoreboard drained", 32'(sb_q.size()), 32'd0);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      reset = 1'b1;
      #1;
      check("boot_addr after mid-boot reset", 32'(boot_addr), 32'd0);
      check("hold after mid-boot reset", 32'(hold), 32'd1);
      check("sram_we after mid-boot reset", 32'(sram_we), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      run_boot();

      // boot image recopied, earlier SRAM and video contents retained
      access(20'hFF000, 1'b0, 8'h00);
      access(20'hFF001, 1'b0, 8'h00);
      access(20'hFF002, 1'b0, 8'h00);
      access(20'h00001, 1'b0, 8'h00);
      access(20'hB8000, 1'b0, 8'h00);
      access(20'hC0000, 1'b0, 8'h00);
      @(negedge clock);
      repeat (3) @(negedge clock);
      check("scoreboard drained at end", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
